// File: rtl/hls_run_pkg.sv
// hls_run_pkg: shared FSM states, result status codes and result record type
// for the Bambu core run sequencer.
package hls_run_pkg;
   typedef enum logic [2:0] {IDLE, HOLD, START, WAIT, REPORT} state_t;
   localparam logic [1:0] ST_FAIL    = 2'b00;
   localparam logic [1:0] ST_PASS    = 2'b01;
   localparam logic [1:0] ST_NOCHECK = 2'b10;
   localparam logic [1:0] ST_TIMEOUT = 2'b11;
   // Record field widths; the sequencer's CNT_W/RUN_W must match these.
   localparam int REC_CNT_W = 32;
   localparam int REC_RUN_W = 8;
   typedef struct packed {
      logic [1:0]           status;
      logic [REC_CNT_W-1:0] cycles;
      logic [REC_RUN_W-1:0] run;
   } res_rec_t;
endpackage

// File: rtl/hls_run_result_fifo.sv
// hls_run_result_fifo: first-word-fall-through record FIFO; a push into a full
// FIFO is accepted when a pop happens on the same edge.
module hls_run_result_fifo
   import hls_run_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     i_clock,
   input  logic     i_reset,
   input  logic     i_push,
   input  res_rec_t i_data,
   input  logic     i_pop,
   output res_rec_t o_head,
   output logic     o_empty,
   output logic     o_full
);
   localparam int AW = $clog2(DEPTH);
   res_rec_t       r_mem [DEPTH];
   logic [AW:0]    r_wr, r_rd;
   logic           w_pop, w_push;
   assign o_empty = r_wr == r_rd;
   assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);
   assign o_head  = r_mem[r_rd[AW-1:0]];
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_wr <= '0;
         r_rd <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr[AW-1:0]] <= i_data;
            r_wr <= r_wr + 1'b1;
         end
         if (w_pop) r_rd <= r_rd + 1'b1;
      end
   end
endmodule

// File: rtl/hls_run_sequencer.sv
// hls_run_sequencer: resets, starts and times a Bambu core over a number of
// runs, with a watchdog, queuing one {status, cycles, run} record per run.
module hls_run_sequencer
   import hls_run_pkg::*;
#(
   parameter int CNT_W          = 32,
   parameter int RUN_W          = 8,
   parameter int TIMEOUT_CYCLES = 200000000,
   parameter int RST_CYCLES     = 2,
   parameter int RES_DEPTH      = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             go,
   input  logic [RUN_W-1:0] cfg_runs,
   output logic             busy,
   output logic             dut_reset_n,
   output logic             start_port,
   input  logic             done_port,
   input  logic             chk_valid,
   input  logic             chk_pass,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [1:0]       res_status,
   output logic [CNT_W-1:0] res_cycles,
   output logic [RUN_W-1:0] res_run,
   output logic             overflow
);
   localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] RST_END = CNT_W'(RST_CYCLES - 1);
   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [RUN_W-1:0] r_runs, r_run;
   logic [1:0]       r_status, w_status;
   logic             r_busy, r_rstn, r_start, r_ovf;
   logic             w_full, w_empty, w_pop, w_push, w_last, w_timeout;
   res_rec_t         w_rec, w_head;
   assign w_pop     = res_ready & ~w_empty;
   assign w_push    = (r_state == REPORT) & (~w_full | w_pop);
   assign w_last    = (r_run == r_runs - 1'b1) | (r_status == ST_TIMEOUT);
   assign w_timeout = r_cnt == TO_CNT;
   assign w_status  = chk_valid ? (chk_pass ? ST_PASS : ST_FAIL) : ST_NOCHECK;
   assign w_rec     = '{status: r_status, cycles: r_cnt, run: r_run};
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = go ? HOLD : IDLE;
         HOLD:    w_next = (r_cnt == RST_END) ? START : HOLD;
         START:   w_next = done_port ? REPORT : WAIT;
         WAIT:    w_next = (done_port | w_timeout) ? REPORT : WAIT;
         REPORT:  w_next = w_push ? (w_last ? IDLE : HOLD) : REPORT;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end
   // Control outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_busy   <= 1'b0;
         r_rstn   <= 1'b0;
         r_start  <= 1'b0;
         r_ovf    <= 1'b0;
         r_cnt    <= '0;
         r_runs   <= '0;
         r_run    <= '0;
         r_status <= ST_FAIL;
      end else begin
         r_busy  <= w_next != IDLE;
         r_rstn  <= w_next inside {START, WAIT, REPORT};
         r_start <= w_next == START;
         case (r_state)
            IDLE: if (go) begin
               r_runs <= (cfg_runs == '0) ? RUN_W'(1) : cfg_runs;
               r_run  <= '0;
               r_ovf  <= 1'b0;
               r_cnt  <= '0;
            end
            HOLD:  r_cnt <= (r_cnt == RST_END) ? CNT_W'(1) : r_cnt + 1'b1;
            START: if (done_port) r_status <= w_status; else r_cnt <= r_cnt + 1'b1;
            WAIT: begin
               if (done_port)      r_status <= w_status;
               else if (w_timeout) r_status <= ST_TIMEOUT;
               else                r_cnt    <= r_cnt + 1'b1;
            end
            REPORT: begin
               if (!w_push) r_ovf <= 1'b1;
               else if (!w_last) begin
                  r_run <= r_run + 1'b1;
                  r_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end
   hls_run_result_fifo #(.DEPTH(RES_DEPTH)) u_fifo (
      .i_clock (clock),
      .i_reset (reset),
      .i_push  (w_push),
      .i_data  (w_rec),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full)
   );
   assign busy        = r_busy;
   assign dut_reset_n = r_rstn;
   assign start_port  = r_start;
   assign overflow    = r_ovf;
   assign res_valid   = ~w_empty;
   assign res_status  = w_head.status;
   assign res_cycles  = w_head.cycles;
   assign res_run     = w_head.run;
endmodule

// File: tb/tb_hls_run_sequencer.sv
// tb_hls_run_sequencer: directed runs against a behavioural core model with a
// record scoreboard filled at go time and drained by a FIFO monitor.
module tb_hls_run_sequencer;
   import hls_run_pkg::*;
   logic        clock = 1'b0, reset = 1'b0, go = 1'b0, done_port = 1'b0;
   logic        chk_valid = 1'b0, chk_pass = 1'b0, res_ready = 1'b1;
   logic [7:0]  cfg_runs = '0;
   logic        busy, dut_reset_n, start_port, res_valid, overflow;
   logic [1:0]  res_status;
   logic [31:0] res_cycles;
   logic [7:0]  res_run;
   int          total = 0, bad = 0;
   int          core_delay = -1, cd = -1, n_start = 0;
   logic        rn1 = 1'b0, rn2 = 1'b0, prev_start = 1'b0;
   res_rec_t    exp_q [$];
   res_rec_t    e;

   hls_run_sequencer #(
      .CNT_W(32), .RUN_W(8), .TIMEOUT_CYCLES(20), .RST_CYCLES(2), .RES_DEPTH(4)
   ) dut (
      .clock(clock), .reset(reset), .go(go), .cfg_runs(cfg_runs), .busy(busy),
      .dut_reset_n(dut_reset_n), .start_port(start_port), .done_port(done_port),
      .chk_valid(chk_valid), .chk_pass(chk_pass), .res_valid(res_valid),
      .res_ready(res_ready), .res_status(res_status), .res_cycles(res_cycles),
      .res_run(res_run), .overflow(overflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic launch(input logic [7:0] runs);
      cfg_runs = runs;
      go = 1'b1;
      cyc();
      go = 1'b0;
      chk("busy_after_go", busy, 1'b1);
      chk("overflow_cleared_by_go", overflow, 1'b0);
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n = 0;
      while ((busy || res_valid) && n < limit) begin
         cyc();
         n++;
      end
      chk({tag, "_reached_idle"}, n < limit, 1'b1);
      chk({tag, "_scoreboard_empty"}, exp_q.size(), 0);
   endtask

   // Core model: answers each start pulse after core_delay cycles (-1 = never).
   always @(negedge clock) begin
      if (reset) cd = -1;
      if (start_port) begin
         n_start++;
         chk("start_after_two_reset_cycles", {prev_start, rn2, rn1, dut_reset_n}, 4'b0001);
         cd = core_delay;
      end
      done_port = (cd == 0);
      if (cd >= 0) cd--;
      rn2 = rn1;
      rn1 = dut_reset_n;
      prev_start = start_port;
   end

   always @(negedge clock) begin
      if (!reset && res_valid && res_ready) begin
         chk("record_was_expected", exp_q.size() > 0, 1'b1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rec_status", res_status, e.status);
            chk("rec_cycles", res_cycles, e.cycles);
            chk("rec_run", res_run, e.run);
         end
      end
   end

   initial begin
      int n;
      #1 reset = 1'b1;
      repeat (3) cyc();
      chk("reset_outputs", {busy, dut_reset_n, start_port, res_valid, res_status, res_cycles, res_run, overflow}, '0);
      reset = 1'b0;
      cyc();
      chk("idle_outputs", {busy, dut_reset_n, start_port, res_valid, overflow}, '0);

      // single run, pass, done 5 cycles after start
      core_delay = 5; chk_valid = 1'b1; chk_pass = 1'b1; n_start = 0;
      exp_q.push_back('{ST_PASS, 32'd6, 8'd0});
      launch(8'd1);
      wait_idle("t1", 100);
      chk("t1_starts", n_start, 1);
      chk("t1_busy_low", busy, 1'b0);

      // done in the START cycle, no checker verdict
      core_delay = 0; chk_valid = 1'b0; n_start = 0;
      exp_q.push_back('{ST_NOCHECK, 32'd1, 8'd0});
      launch(8'd1);
      wait_idle("t2", 100);
      chk("t2_starts", n_start, 1);

      // two failing runs back to back
      core_delay = 2; chk_valid = 1'b1; chk_pass = 1'b0; n_start = 0;
      exp_q.push_back('{ST_FAIL, 32'd3, 8'd0});
      exp_q.push_back('{ST_FAIL, 32'd3, 8'd1});
      launch(8'd2);
      wait_idle("t2b", 100);
      chk("t2b_starts", n_start, 2);

      // watchdog aborts the remaining runs
      core_delay = -1; n_start = 0;
      exp_q.push_back('{ST_TIMEOUT, 32'd20, 8'd0});
      launch(8'd3);
      wait_idle("t3", 200);
      repeat (10) cyc();
      chk("t3_starts", n_start, 1);

      // FIFO fills with the host stalled, then drains in order
      core_delay = 3; chk_pass = 1'b1; n_start = 0; res_ready = 1'b0;
      for (int i = 0; i < 6; i++) exp_q.push_back('{ST_PASS, 32'd4, 8'(i)});
      launch(8'd6);
      n = 0;
      while (!overflow && n < 300) begin
         cyc();
         n++;
      end
      chk("t4_overflow_seen", n < 300, 1'b1);
      repeat (10) cyc();
      chk("t4_stalled_starts", n_start, 5);
      chk("t4_stalled_busy", {busy, dut_reset_n, overflow, res_valid}, 4'hf);
      chk("t4_head_run", res_run, exp_q[0].run);
      chk("t4_head_cycles", res_cycles, exp_q[0].cycles);
      res_ready = 1'b1;
      wait_idle("t4", 300);
      chk("t4_starts", n_start, 6);
      chk("t4_overflow_sticky", overflow, 1'b1);

      // cfg_runs=0 acts as one run
      core_delay = 1; n_start = 0;
      exp_q.push_back('{ST_PASS, 32'd2, 8'd0});
      launch(8'd0);
      wait_idle("t5", 100);
      repeat (10) cyc();
      chk("t5_starts", n_start, 1);

      // reset during WAIT of run 2 of 4
      core_delay = 10; n_start = 0;
      for (int i = 0; i < 4; i++) exp_q.push_back('{ST_PASS, 32'd11, 8'(i)});
      launch(8'd4);
      n = 0;
      while (n_start < 3 && n < 200) begin
         cyc();
         n++;
      end
      chk("t6_third_start_seen", n < 200, 1'b1);
      repeat (3) cyc();
      chk("t6_mid_wait", {busy, dut_reset_n}, 2'b11);
      #2 reset = 1'b1;
      #1;
      chk("t6_async_reset_outputs", {busy, dut_reset_n, start_port, res_valid, res_status, res_cycles, res_run, overflow}, '0);
      chk("t6_discarded_records", exp_q.size(), 2);
      exp_q.delete();
      repeat (2) cyc();
      reset = 1'b0;
      repeat (3) cyc();
      chk("t6_post_reset_idle", {busy, dut_reset_n, start_port, res_valid}, 4'h0);
      n_start = 0;
      exp_q.push_back('{ST_PASS, 32'd11, 8'd0});
      launch(8'd1);
      wait_idle("t6", 200);
      chk("t6_restart_starts", n_start, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
